// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the motor drive PWM back-end.
package mtr_drv_pkg;

  localparam int unsigned PWM_PERIOD   = 4096;
  localparam logic [11:0] DUTY_OFFSET  = 12'h800;
  localparam int unsigned DEAD_DEFAULT = 32;

  typedef logic [11:0] duty_t;

  // Offset-binary mapping: -2048 -> 0, 0 -> 0x800, 2047 -> 0xFFF.
  function automatic duty_t spd_to_duty(input logic [11:0] spd);
    return spd ^ DUTY_OFFSET;
  endfunction

  // Raw PWM next state: clear on duty match wins over set at period start,
  // so a zero duty never produces a high cycle.
  function automatic logic pwm_raw_next(input logic raw, input logic at_zero,
                                        input logic at_duty);
    logic nxt;
    nxt = raw;
    if (at_zero) nxt = 1'b1;
    if (at_duty) nxt = 1'b0;
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_nonoverlap.sv
// Dead-time inserter: splits one raw PWM into a complementary pair that is
// never high at the same time, holding both low for DEAD clocks per raw edge.
module pwm_nonoverlap #(
  parameter int unsigned DEAD = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic PWM1,
  output logic PWM2
);

  localparam logic [7:0] DeadLoad = 8'(DEAD);

  logic       raw_prev_q, raw_prev_d;
  logic [7:0] dead_q, dead_d;
  logic       pwm1_q, pwm1_d;
  logic       pwm2_q, pwm2_d;

  // Next state: an edge restarts the window; the last window cycle
  // (dead_q == 1) already releases the outputs so the gap is exactly DEAD.
  always_comb begin
    raw_prev_d = raw;
    dead_d     = dead_q;
    pwm1_d     = 1'b0;
    pwm2_d     = 1'b0;
    if (raw != raw_prev_q) begin
      dead_d = DeadLoad;
    end else if (dead_q > 8'd1) begin
      dead_d = dead_q - 8'd1;
    end else begin
      dead_d = 8'd0;
      pwm1_d = raw;
      pwm2_d = ~raw;
    end
  end

  // State registers; reset behaves like a fresh edge so outputs start low.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_prev_q <= 1'b0;
      dead_q     <= DeadLoad;
      pwm1_q     <= 1'b0;
      pwm2_q     <= 1'b0;
    end else begin
      raw_prev_q <= raw_prev_d;
      dead_q     <= dead_d;
      pwm1_q     <= pwm1_d;
      pwm2_q     <= pwm2_d;
    end
  end

  assign PWM1 = pwm1_q;
  assign PWM2 = pwm2_q;

endmodule

// File: rtl/mtr_drv_pwm.sv
// Motor drive back-end: two speed commands -> two gated, dead-time protected
// H-bridge PWM pairs sharing one free-running period counter.
module mtr_drv_pwm
  import mtr_drv_pkg::*;
#(
  parameter int unsigned DEAD  = DEAD_DEFAULT,
  parameter int unsigned CNT_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        en,
  input  logic        ovr_i,
  output logic        lft_PWM1,
  output logic        lft_PWM2,
  output logic        rght_PWM1,
  output logic        rght_PWM2,
  output logic        period_strt,
  output logic        fault
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_zero, cnt_wrap;
  duty_t            lft_duty_q, lft_duty_d;
  duty_t            rght_duty_q, rght_duty_d;
  logic             lft_raw_q, lft_raw_d;
  logic             rght_raw_q, rght_raw_d;
  logic             fault_q, fault_d;
  logic             gate;
  logic             period_strt_q;
  logic             lft_no1, lft_no2, rght_no1, rght_no2;
  logic             lft_pwm1_q, lft_pwm2_q, rght_pwm1_q, rght_pwm2_q;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_wrap = (cnt_q == '1);

  // Period counter, duty latches and raw PWM generation.
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    lft_duty_d  = cnt_wrap ? spd_to_duty(lft_spd)  : lft_duty_q;
    rght_duty_d = cnt_wrap ? spd_to_duty(rght_spd) : rght_duty_q;
    lft_raw_d   = pwm_raw_next(lft_raw_q, cnt_zero, cnt_q == lft_duty_q);
    rght_raw_d  = pwm_raw_next(rght_raw_q, cnt_zero, cnt_q == rght_duty_q);
  end

  // Fault latch and output gate; the gate uses the next fault value so the
  // bridge is released in the same cycle the fault flag appears.
  always_comb begin
    fault_d = fault_q | ovr_i;
    gate    = en & ~fault_d;
  end

  // All registered state, including the gated bridge outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      lft_duty_q    <= DUTY_OFFSET;
      rght_duty_q   <= DUTY_OFFSET;
      lft_raw_q     <= 1'b0;
      rght_raw_q    <= 1'b0;
      fault_q       <= 1'b0;
      period_strt_q <= 1'b0;
      lft_pwm1_q    <= 1'b0;
      lft_pwm2_q    <= 1'b0;
      rght_pwm1_q   <= 1'b0;
      rght_pwm2_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      lft_duty_q    <= lft_duty_d;
      rght_duty_q   <= rght_duty_d;
      lft_raw_q     <= lft_raw_d;
      rght_raw_q    <= rght_raw_d;
      fault_q       <= fault_d;
      period_strt_q <= cnt_zero;
      lft_pwm1_q    <= lft_no1 & gate;
      lft_pwm2_q    <= lft_no2 & gate;
      rght_pwm1_q   <= rght_no1 & gate;
      rght_pwm2_q   <= rght_no2 & gate;
    end
  end

  pwm_nonoverlap #(
    .DEAD (DEAD)
  ) u_lft_no (
    .clk  (clk),
    .rst  (rst),
    .raw  (lft_raw_q),
    .PWM1 (lft_no1),
    .PWM2 (lft_no2)
  );

  pwm_nonoverlap #(
    .DEAD (DEAD)
  ) u_rght_no (
    .clk  (clk),
    .rst  (rst),
    .raw  (rght_raw_q),
    .PWM1 (rght_no1),
    .PWM2 (rght_no2)
  );

  assign lft_PWM1    = lft_pwm1_q;
  assign lft_PWM2    = lft_pwm2_q;
  assign rght_PWM1   = rght_pwm1_q;
  assign rght_PWM2   = rght_pwm2_q;
  assign period_strt = period_strt_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Bench for mtr_drv_pwm: cycle model built from period/duty/dead-time rules,
// per-cycle compare, plus hand-computed per-period high-time expectations.
module tb_mtr_drv_pwm;

  localparam int DEAD = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] lft_spd, rght_spd;
  logic        en, ovr_i;
  logic        lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, period_strt, fault;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  mtr_drv_pwm #(
    .DEAD  (DEAD),
    .CNT_W (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lft_spd     (lft_spd),
    .rght_spd    (rght_spd),
    .en          (en),
    .ovr_i       (ovr_i),
    .lft_PWM1    (lft_PWM1),
    .lft_PWM2    (lft_PWM2),
    .rght_PWM1   (rght_PWM1),
    .rght_PWM2   (rght_PWM2),
    .period_strt (period_strt),
    .fault       (fault)
  );

  // Behavioural model. Index 0 = left, 1 = right.
  int m_cnt;
  int m_duty [2];
  int m_age  [2];  // cycles since the raw signal last changed (or reset)
  bit m_no1  [2];
  bit m_no2  [2];
  bit m_o1   [2];
  bit m_o2   [2];
  bit m_fault, m_ps;

  // Raw PWM is high for counts 1..duty of each period.
  function automatic bit raw_of(input int c, input int d);
    return (c >= 1) && (c <= d);
  endfunction

  always @(posedge clk) begin
    bit raw_o [2];
    bit raw_n;
    bit f_next;
    if (rst) begin
      m_cnt   = 0;
      m_fault = 1'b0;
      m_ps    = 1'b0;
      for (int s = 0; s < 2; s++) begin
        m_duty[s] = 2048;
        m_age[s]  = 1;
        m_no1[s]  = 1'b0;
        m_no2[s]  = 1'b0;
        m_o1[s]   = 1'b0;
        m_o2[s]   = 1'b0;
      end
    end else begin
      f_next = m_fault | ovr_i;
      for (int s = 0; s < 2; s++) begin
        raw_o[s] = raw_of(m_cnt, m_duty[s]);
        m_o1[s]  = m_no1[s] & en & ~f_next;
        m_o2[s]  = m_no2[s] & en & ~f_next;
        m_no1[s] = raw_o[s] && (m_age[s] >= DEAD);
        m_no2[s] = !raw_o[s] && (m_age[s] >= DEAD);
      end
      m_ps = (m_cnt == 0);
      if (m_cnt == 4095) begin
        m_duty[0] = $signed(lft_spd) + 2048;
        m_duty[1] = $signed(rght_spd) + 2048;
      end
      m_cnt = (m_cnt + 1) % 4096;
      for (int s = 0; s < 2; s++) begin
        raw_n = raw_of(m_cnt, m_duty[s]);
        if (raw_n != raw_o[s]) m_age[s] = 0;
        else if (m_age[s] < 100000) m_age[s] = m_age[s] + 1;
      end
      m_fault = f_next;
    end
  end

  // Per-period high-time counters, windows delimited by period_strt.
  int cur [4];
  int last [4];

  // Compare process: every cycle against the model, plus overlap rule.
  always @(negedge clk) begin
    logic [5:0] act, exp;
    cycle++;
    if (period_strt) begin
      last = cur;
      cur  = '{0, 0, 0, 0};
    end
    cur[0] += int'(lft_PWM1);
    cur[1] += int'(lft_PWM2);
    cur[2] += int'(rght_PWM1);
    cur[3] += int'(rght_PWM2);
    if (chk_on) begin
      act = {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, fault, period_strt};
      exp = {m_o1[0], m_o2[0], m_o1[1], m_o2[1], m_fault, m_ps};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_cmp cycle %0d: actual=%b required=%b", cycle, act, exp);
      end
      checks++;
      if ((lft_PWM1 & lft_PWM2) | (rght_PWM1 & rght_PWM2)) begin
        errors++;
        $display("FAIL overlap cycle %0d: actual=%b%b/%b%b required=no pair both high",
                 cycle, lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Wait for the next period_strt pulse; returns just after that negedge.
  task automatic wait_ps();
    int n = 0;
    @(negedge clk);
    while (!period_strt && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!period_strt) begin
      checks++;
      errors++;
      $display("FAIL wait_ps: actual=timeout required=pulse within 5000 cycles");
    end
    #1;
  endtask

  initial begin
    int hi;
    rst      = 1'b1;
    en       = 1'b0;
    ovr_i    = 1'b0;
    lft_spd  = 12'h000;
    rght_spd = 12'h000;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("reset_outputs", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2}), 0);
    check("reset_fault", int'(fault), 0);
    check("reset_period_strt", int'(period_strt), 0);

    // Mid-scale left, full-scale right.
    lft_spd  = 12'h000;
    rght_spd = 12'h7FF;
    en       = 1'b1;
    rst      = 1'b0;
    repeat (4) wait_ps();
    check("lft_pwm1_mid", last[0], 2016);
    check("lft_pwm2_mid", last[1], 2016);
    check("rght_pwm1_full", last[2], 4063);
    check("rght_pwm2_full", last[3], 0);

    // Speed change at cnt=100 only takes effect next period.
    repeat (99) @(negedge clk);
    lft_spd = 12'h400;
    wait_ps();
    check("lft_pwm1_before_latch", last[0], 2016);
    wait_ps();
    check("lft_pwm1_after_latch", last[0], 3040);

    // One-cycle over-current pulse at cnt=500.
    repeat (499) @(negedge clk);
    ovr_i = 1'b1;
    @(negedge clk);
    ovr_i = 1'b0;
    check("fault_set", int'(fault), 1);
    check("fault_outputs_low", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2}), 0);
    wait_ps();
    wait_ps();
    check("fault_period_hi", last[0] + last[1] + last[2] + last[3], 0);
    check("fault_sticky", int'(fault), 1);

    // Reset at cnt=1000 clears the fault and restarts the dead window.
    repeat (999) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_fault_clr", int'(fault), 0);
    check("rst_outputs_low", int'({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2}), 0);
    rst     = 1'b0;
    lft_spd = 12'h800;
    @(negedge clk);
    check("rst_period_strt", int'(period_strt), 1);
    hi = 0;
    for (int i = 0; i < DEAD; i++) begin
      hi += int'(lft_PWM1 | lft_PWM2 | rght_PWM1 | rght_PWM2);
      @(negedge clk);
    end
    check("rst_dead_window", hi, 0);

    // Minimum duty: left high side never on, low side on all period.
    wait_ps();
    wait_ps();
    check("lft_pwm1_min", last[0], 0);
    check("lft_pwm2_min", last[1], 4096);

    // Random speeds and enable toggling against the model.
    for (int i = 0; i < 16000; i++) begin
      @(negedge clk);
      if ($urandom_range(299, 0) == 0) lft_spd = 12'($urandom);
      if ($urandom_range(299, 0) == 0) rght_spd = 12'($urandom);
      if ($urandom_range(499, 0) == 0) en = ~en;
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
